// File: rtl/lfo_pkg.sv
// lfo_pkg: shared definitions for the modulated delay-line reader.
//   - default geometry (buffer address width, fractional delay bits)
//   - FSM state encoding (localparam constants of a 3-bit state type)
//   - delay clamp constants and the depth scaling shift
package lfo_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int FRAC_W_DEF     = 8;
    localparam int BASE_DELAY_DEF = 256;

    localparam int SAMPLE_W = 16;
    localparam int LFO_W    = 16;
    localparam int DEPTH_W  = 4;

    // lfo * depth is shifted down by this amount so depth=15 gives just
    // under one full LFO swing in fractional delay units.
    localparam int DEPTH_SHIFT = 4;

    // Delay clamp: [DELAY_MIN_INT, 2^ADDR_W - DELAY_MAX_MARGIN] whole samples.
    // The upper margin keeps tap B (delay+1) from landing on the write slot.
    localparam int DELAY_MIN_INT    = 1;
    localparam int DELAY_MAX_MARGIN = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WRITE  = 3'd1;
    localparam state_t ST_READ_A = 3'd2;
    localparam state_t ST_READ_B = 3'd3;
    localparam state_t ST_INTERP = 3'd4;
    localparam state_t ST_OUT    = 3'd5;

endpackage

// File: rtl/lfo_delay_ram.sv
// lfo_delay_ram: single-port synchronous RAM, 2^ADDR_W x DATA_W, one-cycle
// read latency. Contents are not reset.
//   clk   in   clock
//   we    in   write enable (write takes place at the clock edge)
//   addr  in   shared read/write address
//   wdata in   write data
//   rdata out  data at addr, registered (valid the cycle after addr)
module lfo_delay_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lfo_delay_tap.sv
// lfo_delay_tap: LFO-modulated delay-line reader (chorus / vibrato).
// Each accepted sample is written into a circular buffer, then the buffer is
// read at BASE_DELAY + (lfo * depth >>> 4) / 2^FRAC_W samples back, blending
// two neighbouring taps by the fractional part of the delay.
//
// Build option: define LFO_INTERP_EN for linear interpolation between taps.
// Without it the output is the nearest-lower tap (fraction ignored); the FSM
// still walks every state so timing is identical in both builds.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   sampleValid  in   one-cycle strobe, sampleIn holds a new audio sample
//   sampleIn     in   signed 16-bit audio sample
//   lfoWave      in   signed 16-bit LFO value
//   lfoNewVal    in   one-cycle flag, lfoWave holds a new value
//   depth        in   modulation depth, 0 = no modulation
//   sampleOut    out  signed delayed sample
//   outValid     out  one-cycle pulse, sampleOut updated
//   busy         out  FSM is not idle
//   overrun      out  sticky: a sampleValid arrived while busy
//   state_dbg    out  current FSM state (lfo_pkg ST_* encoding)
//
// Handshake: there is no ready. A sampleValid strobe is accepted only when
// busy is low; the result appears with outValid high during the fifth cycle
// after the accepting edge. A strobe seen while busy is dropped and latches
// overrun until reset. Producers must space strobes at least 6 cycles apart.
module lfo_delay_tap
    import lfo_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BASE_DELAY = BASE_DELAY_DEF,
    parameter int FRAC_W     = FRAC_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sampleValid,
    input  logic signed [SAMPLE_W-1:0] sampleIn,
    input  logic signed [LFO_W-1:0]    lfoWave,
    input  logic                       lfoNewVal,
    input  logic [DEPTH_W-1:0]         depth,
    output logic signed [SAMPLE_W-1:0] sampleOut,
    output logic                       outValid,
    output logic                       busy,
    output logic                       overrun,
    output state_t                     state_dbg
);

    localparam int Q_W    = ADDR_W + FRAC_W;
    localparam int SUM_W  = ADDR_W + FRAC_W + 2;
    localparam int PROD_W = LFO_W + DEPTH_W + 1;

    localparam logic signed [SUM_W-1:0] BASE_Q = SUM_W'(BASE_DELAY << FRAC_W);
    localparam logic signed [SUM_W-1:0] MIN_Q  = SUM_W'(DELAY_MIN_INT << FRAC_W);
    localparam logic signed [SUM_W-1:0] MAX_Q  =
        SUM_W'(((1 << ADDR_W) - DELAY_MAX_MARGIN) << FRAC_W);
    localparam logic [ADDR_W-1:0] FILL_MAX = {ADDR_W{1'b1}};

    state_t                     state;
    logic [ADDR_W-1:0]          wr_ptr;
    logic [ADDR_W-1:0]          fill_cnt;
    logic signed [LFO_W-1:0]    lfo_reg;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic [ADDR_W-1:0]          addr_a;
    logic [ADDR_W-1:0]          addr_b;
    logic [FRAC_W-1:0]          frac_q;
    logic                       valid_a;
    logic                       valid_b;
    logic signed [SAMPLE_W-1:0] tap_a;

    logic signed [PROD_W-1:0]   lfo_prod;
    logic signed [PROD_W-1:0]   lfo_scaled;
    logic signed [SUM_W-1:0]    delay_sum;
    logic [Q_W-1:0]             delay_q;
    logic [ADDR_W-1:0]          d_int;
    logic [FRAC_W-1:0]          d_frac;
    logic [ADDR_W-1:0]          fill_next;

    logic                       ram_we;
    logic [ADDR_W-1:0]          ram_addr;
    logic [SAMPLE_W-1:0]        ram_rdata;
    logic signed [SAMPLE_W-1:0] y;

    // Delay for the sample being written; only consumed in WRITE, where
    // lfo_reg already reflects an LFO update coincident with the strobe.
    always_comb begin
        lfo_prod   = lfo_reg * $signed({1'b0, depth});
        lfo_scaled = lfo_prod >>> DEPTH_SHIFT;
        delay_sum  = BASE_Q + SUM_W'(lfo_scaled);
        if (delay_sum < MIN_Q) begin
            delay_q = MIN_Q[Q_W-1:0];
        end else if (delay_sum > MAX_Q) begin
            delay_q = MAX_Q[Q_W-1:0];
        end else begin
            delay_q = delay_sum[Q_W-1:0];
        end
        d_int  = delay_q[Q_W-1:FRAC_W];
        d_frac = delay_q[FRAC_W-1:0];
        // Count includes the sample being written this cycle.
        fill_next = (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + ADDR_W'(1);
    end

    // Single RAM port: write slot in WRITE, tap A in READ_A, tap B in READ_B.
    always_comb begin
        ram_we = (state == ST_WRITE);
        case (state)
            ST_WRITE:  ram_addr = wr_ptr;
            ST_READ_B: ram_addr = addr_b;
            default:   ram_addr = addr_a;
        endcase
    end

    lfo_delay_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (sample_q),
        .rdata (ram_rdata)
    );

`ifdef LFO_INTERP_EN
    logic signed [SAMPLE_W-1:0]        tap_b;
    logic signed [SAMPLE_W:0]          tap_diff;
    logic signed [SAMPLE_W+FRAC_W+1:0] tap_step;

    // ram_rdata holds tap B during INTERP. The blend stays between the taps,
    // so the 16-bit sum cannot overflow.
    always_comb begin
        tap_b    = valid_b ? ram_rdata : '0;
        tap_diff = {tap_b[SAMPLE_W-1], tap_b} - {tap_a[SAMPLE_W-1], tap_a};
        tap_step = tap_diff * $signed({1'b0, frac_q});
        y        = tap_a + SAMPLE_W'(tap_step >>> FRAC_W);
    end
`else
    logic unused_interp;
    assign unused_interp = ^{frac_q, valid_b};

    always_comb begin
        y = tap_a;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            lfo_reg   <= '0;
            sample_q  <= '0;
            addr_a    <= '0;
            addr_b    <= '0;
            frac_q    <= '0;
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            tap_a     <= '0;
            sampleOut <= '0;
            outValid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (lfoNewVal) begin
                lfo_reg <= lfoWave;
            end
            if (sampleValid && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            outValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sampleValid) begin
                        sample_q <= sampleIn;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_a   <= wr_ptr - d_int;
                    addr_b   <= wr_ptr - d_int - ADDR_W'(1);
                    frac_q   <= d_frac;
                    // A tap older than anything written since reset reads 0.
                    valid_a  <= (d_int < fill_next);
                    valid_b  <= (({1'b0, d_int} + (ADDR_W+1)'(1)) < {1'b0, fill_next});
                    wr_ptr   <= wr_ptr + ADDR_W'(1);
                    fill_cnt <= fill_next;
                    state    <= ST_READ_A;
                end
                ST_READ_A: begin
                    state <= ST_READ_B;
                end
                ST_READ_B: begin
                    tap_a <= valid_a ? ram_rdata : '0;
                    state <= ST_INTERP;
                end
                ST_INTERP: begin
                    // Result is registered on leaving INTERP so outValid is
                    // high for the whole OUT cycle.
                    sampleOut <= y;
                    outValid  <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule
